eth_10g_mac_rx_frame_decoder: RTL and testbench
===============================================

# eth_10g_mac_rx_frame_decoder

Receive-path frame decoder for the 10G MAC: sits directly upstream of the RX frame-status timing adapter and feeds it the 64-bit Avalon-ST frame stream. Registers each beat once, counts frame length, classifies the destination address (unicast, multicast or broadcast), detects VLAN tags and flags undersize or oversize frames. Length errors are merged into `out_error` on the EOP beat, and a per-frame status word is presented alongside the EOP beat.

## Interface
- `MIN_FRAME_LEN`, 64, minimum legal frame length in bytes, including FCS.
- `MAX_FRAME_LEN`, 1518, maximum legal untagged length in bytes; the tagged limit is +4.
- `clk` in 1: single clock, rising edge.
- `reset_n` in 1: asynchronous, active-low reset. One clock; asynchronous active-low reset.
- `in_valid`, `in_ready` (out), `in_data[63:0]`, `in_startofpacket`, `in_endofpacket`, `in_empty[2:0]`, `in_error`: Avalon-ST sink.
  - Symbol 0 (the first byte on the wire) is `in_data[63:56]`.
  - `in_empty` is valid only on EOP beats.
- `out_valid`, `out_ready` (in), `out_data[63:0]`, `out_startofpacket`, `out_endofpacket`, `out_empty[2:0]`, `out_error`: Avalon-ST source with the same format.
- `status_valid` out 1: asserted while the registered EOP beat of a tracked frame is presented.
- `status_length` out 16: frame length in bytes, saturating at 0xFFFF.
- `status_bcast`, `status_mcast`, `status_vlan`, `status_undersize`, `status_oversize` out 1 each: frame classification flags.

## Operation
- **Pipeline:** one output register stage.
  - `in_ready = out_ready | ~out_valid` (combinational).
  - A beat is accepted when `in_valid & in_ready`.
  - The register loads on accept. `out_valid` clears when `out_ready` is high and nothing is accepted.
- **FSM**, state changes on accepted beats only:
  - IDLE: SOP → IN_FRAME. SOP+EOP → stay IDLE; the frame is complete in one beat.
  - IN_FRAME: EOP → IDLE. SOP → restart tracking; the prior unterminated frame gets no status.
  - Non-SOP beats in IDLE pass through unchanged, with no status and no error modification.
- **Byte counter** (17-bit internal):
  - Loaded with 8 on a non-EOP SOP beat; +8 on each non-EOP beat.
  - EOP length = count + 8 − `in_empty`, where count is 0 for an SOP+EOP beat.
  - Saturated to 16 bits.
- **SOP beat:**
  - bcast = `data[63:16]` == 48'hFFFF_FFFF_FFFF.
  - mcast = `data[56]` & ~bcast.
  - Both flags are latched for the frame.
- **Second beat of frame:** vlan = (`data[31:16]` == 16'h8100). A single-beat frame has vlan = 0.
- **Length checks at EOP:**
  - undersize = len < `MIN_FRAME_LEN`.
  - oversize = len > `MAX_FRAME_LEN` + (vlan ? 4 : 0).
- **Error merge:** on the EOP beat of a tracked frame, `out_error = in_error | undersize | oversize`. Every other beat passes `in_error` unchanged.
- **Status outputs:**
  - Status fields are registered with the EOP beat.
  - `status_valid = out_valid & out_endofpacket & tracked`.
  - Fields hold stable while the beat is stalled.
  - Fields are 0 whenever `status_valid` is 0.

## Timing
- Latency is 1 cycle from an accepted input beat to `out_valid`. Full throughput is one beat per cycle when `out_ready` is held high.
- **Reset values:**
  - All `out_*` and `status_*` outputs are 0.
  - FSM is IDLE; counter and latched flags are 0.
  - `in_ready` is 1, because `out_valid` = 0.
- **Reset mid-frame:** the partial frame is discarded with no status. The next beat is treated from IDLE.
- **Stall:** with `out_ready` = 0 and `out_valid` = 1, `in_ready` = 0. All outputs hold.
- **Simultaneous drain and accept:** when `out_ready` = 1 and `in_valid` = 1, the register is replaced in the same cycle without a bubble.
- **Length saturation:** frames longer than 65535 bytes report 0xFFFF and oversize = 1.

## Test plan
- 64-byte broadcast frame (8 beats, empty = 0, DA all-FF) → `status_valid` on the 8th output beat, length = 64, bcast = 1, error = 0.
- 60-byte frame (8 beats, empty = 4) with DA 01:00:5E:… → length = 60, mcast = 1, undersize = 1, `out_error` = 1 on the EOP beat only.
- 1519-byte untagged frame → oversize = 1, error = 1. 1522-byte frame with 0x8100 at bytes 12–13 → vlan = 1, oversize = 0, error = 0.
- Random `out_ready` toggling over 3 back-to-back frames → output beats are identical to the input sequence, no drop or duplication, and status stays stable during stalls.
- `reset_n` low for 1 cycle at the 3rd beat of a frame, followed by a new 64-byte frame → outputs read 0 during reset, and the single status reports length = 64.
- SOP+EOP single beat with empty = 2 → length = 6, vlan = 0, undersize = 1. A stray non-SOP beat in IDLE → passed through with no `status_valid`.

Source files
------------

// File: rtl/eth_10g_mac_rx_frame_decoder.sv
`default_nettype none
// ============================================================================
// Module      : eth_10g_mac_rx_frame_decoder
// Description : 10G MAC receive-path frame decoder. Registers each 64-bit
//               Avalon-ST beat once, counts frame length, classifies the
//               destination address, detects a VLAN tag and flags undersize
//               or oversize frames. Length errors are merged into out_error
//               on the EOP beat; a per-frame status word rides with that beat.
// Ports       : clk, reset_n             - clock, async active-low reset
//               in_*                     - Avalon-ST sink (symbol 0 = [63:56])
//               out_*                    - Avalon-ST source, same format
//               status_valid             - status word present on EOP beat
//               status_length[15:0]      - frame length, saturates at 0xFFFF
//               status_bcast/mcast/vlan  - destination / tag classification
//               status_undersize/oversize- length check results
// Revision    : 1.0 - initial release
// ============================================================================
module eth_10g_mac_rx_frame_decoder #(
    parameter int MIN_FRAME_LEN = 64,
    parameter int MAX_FRAME_LEN = 1518
) (
    input  logic        clk,
    input  logic        reset_n,
    // Avalon-ST sink
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] in_data,
    input  logic        in_startofpacket,
    input  logic        in_endofpacket,
    input  logic [2:0]  in_empty,
    input  logic        in_error,
    // Avalon-ST source
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out_data,
    output logic        out_startofpacket,
    output logic        out_endofpacket,
    output logic [2:0]  out_empty,
    output logic        out_error,
    // Per-frame status
    output logic        status_valid,
    output logic [15:0] status_length,
    output logic        status_bcast,
    output logic        status_mcast,
    output logic        status_vlan,
    output logic        status_undersize,
    output logic        status_oversize
);

    localparam logic [0:0]  c_ST_IDLE      = 1'b0;
    localparam logic [0:0]  c_ST_IN_FRAME  = 1'b1;
    localparam logic [17:0] c_MIN_LEN      = 18'(MIN_FRAME_LEN);
    localparam logic [17:0] c_MAX_UNTAGGED = 18'(MAX_FRAME_LEN);
    localparam logic [17:0] c_MAX_TAGGED   = 18'(MAX_FRAME_LEN + 4);
    // Once the count passes 16 bits the reported length is already pinned
    // at 0xFFFF, so the counter stops here instead of wrapping.
    localparam logic [16:0] c_CNT_CEIL     = 17'h10000;

    // Tracking state
    logic [0:0]  r_state;
    logic [16:0] r_count;
    logic        r_bcast;
    logic        r_mcast;
    logic        r_vlan;

    // Output register stage
    logic        r_out_valid;
    logic [63:0] r_out_data;
    logic        r_out_sop;
    logic        r_out_eop;
    logic [2:0]  r_out_empty;
    logic        r_out_error;
    logic        r_st_tracked;
    logic [15:0] r_st_length;
    logic        r_st_bcast;
    logic        r_st_mcast;
    logic        r_st_vlan;
    logic        r_st_under;
    logic        r_st_over;

    logic        w_in_ready;
    logic        w_accept;
    logic        w_tracked;
    logic        w_second;
    logic        w_bcast_sop;
    logic        w_mcast_sop;
    logic        w_vlan_tag;
    logic        w_frame_bcast;
    logic        w_frame_mcast;
    logic        w_frame_vlan;
    logic [16:0] w_base;
    logic [17:0] w_len_full;
    logic [15:0] w_len_sat;
    logic        w_undersize;
    logic        w_oversize;
    logic        w_eop_status;

    assign w_in_ready = out_ready | ~r_out_valid;
    assign w_accept   = in_valid & w_in_ready;

    // A beat belongs to a tracked frame if it opens one or arrives mid-frame;
    // non-SOP beats seen in IDLE are stray and pass through untouched.
    assign w_tracked  = in_startofpacket | (r_state == c_ST_IN_FRAME);
    // The counter reads exactly 8 only while the second beat is on the input.
    assign w_second   = ~in_startofpacket & (r_state == c_ST_IN_FRAME) &
                        (r_count == 17'd8);

    assign w_bcast_sop = &in_data[63:16];
    assign w_mcast_sop = in_data[56] & ~w_bcast_sop;
    assign w_vlan_tag  = (in_data[31:16] == 16'h8100);

    assign w_frame_bcast = in_startofpacket ? w_bcast_sop : r_bcast;
    assign w_frame_mcast = in_startofpacket ? w_mcast_sop : r_mcast;
    assign w_frame_vlan  = in_startofpacket ? 1'b0 :
                           (w_second ? w_vlan_tag : r_vlan);

    assign w_base      = in_startofpacket ? 17'd0 : r_count;
    assign w_len_full  = {1'b0, w_base} + 18'd8 - {15'd0, in_empty};
    assign w_len_sat   = (w_len_full > 18'h0FFFF) ? 16'hFFFF : w_len_full[15:0];
    assign w_undersize = (w_len_full < c_MIN_LEN);
    assign w_oversize  = (w_len_full > (w_frame_vlan ? c_MAX_TAGGED : c_MAX_UNTAGGED));
    assign w_eop_status = in_endofpacket & w_tracked;

    // Frame tracking: state, byte count and latched classification
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= c_ST_IDLE;
            r_count <= 17'd0;
            r_bcast <= 1'b0;
            r_mcast <= 1'b0;
            r_vlan  <= 1'b0;
        end else if (w_accept) begin
            if (in_startofpacket) begin
                // SOP always restarts tracking, abandoning any open frame.
                r_bcast <= w_bcast_sop;
                r_mcast <= w_mcast_sop;
                r_vlan  <= 1'b0;
                if (in_endofpacket) begin
                    r_state <= c_ST_IDLE;
                    r_count <= 17'd0;
                end else begin
                    r_state <= c_ST_IN_FRAME;
                    r_count <= 17'd8;
                end
            end else if (r_state == c_ST_IN_FRAME) begin
                if (w_second) begin
                    r_vlan <= w_vlan_tag;
                end
                if (in_endofpacket) begin
                    r_state <= c_ST_IDLE;
                    r_count <= 17'd0;
                end else if (r_count < c_CNT_CEIL) begin
                    r_count <= r_count + 17'd8;
                end
            end
        end
    end

    // Output register: loads on accept, empties when drained with no refill
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_out_valid  <= 1'b0;
            r_out_data   <= 64'd0;
            r_out_sop    <= 1'b0;
            r_out_eop    <= 1'b0;
            r_out_empty  <= 3'd0;
            r_out_error  <= 1'b0;
            r_st_tracked <= 1'b0;
            r_st_length  <= 16'd0;
            r_st_bcast   <= 1'b0;
            r_st_mcast   <= 1'b0;
            r_st_vlan    <= 1'b0;
            r_st_under   <= 1'b0;
            r_st_over    <= 1'b0;
        end else if (w_accept) begin
            r_out_valid  <= 1'b1;
            r_out_data   <= in_data;
            r_out_sop    <= in_startofpacket;
            r_out_eop    <= in_endofpacket;
            r_out_empty  <= in_empty;
            r_out_error  <= in_error | (w_eop_status & (w_undersize | w_oversize));
            r_st_tracked <= w_eop_status;
            r_st_length  <= w_eop_status ? w_len_sat : 16'd0;
            r_st_bcast   <= w_eop_status & w_frame_bcast;
            r_st_mcast   <= w_eop_status & w_frame_mcast;
            r_st_vlan    <= w_eop_status & w_frame_vlan;
            r_st_under   <= w_eop_status & w_undersize;
            r_st_over    <= w_eop_status & w_oversize;
        end else if (out_ready) begin
            // Status fields read zero whenever no status word is presented.
            r_out_valid  <= 1'b0;
            r_st_tracked <= 1'b0;
            r_st_length  <= 16'd0;
            r_st_bcast   <= 1'b0;
            r_st_mcast   <= 1'b0;
            r_st_vlan    <= 1'b0;
            r_st_under   <= 1'b0;
            r_st_over    <= 1'b0;
        end
    end

    assign in_ready          = w_in_ready;
    assign out_valid         = r_out_valid;
    assign out_data          = r_out_data;
    assign out_startofpacket = r_out_sop;
    assign out_endofpacket   = r_out_eop;
    assign out_empty         = r_out_empty;
    assign out_error         = r_out_error;
    assign status_valid      = r_out_valid & r_out_eop & r_st_tracked;
    assign status_length     = r_st_length;
    assign status_bcast      = r_st_bcast;
    assign status_mcast      = r_st_mcast;
    assign status_vlan       = r_st_vlan;
    assign status_undersize  = r_st_under;
    assign status_oversize   = r_st_over;

endmodule
`default_nettype wire

// File: tb/tb_eth_10g_mac_rx_frame_decoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_eth_10g_mac_rx_frame_decoder
// Description : Directed self-checking bench for the RX frame decoder. Every
//               accepted input beat is queued together with its hand-computed
//               expected error bit and status word; a negedge monitor compares
//               the presented output beat against the queue head each cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_eth_10g_mac_rx_frame_decoder;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [63:0] in_data = 64'd0;
    logic        in_startofpacket = 1'b0;
    logic        in_endofpacket = 1'b0;
    logic [2:0]  in_empty = 3'd0;
    logic        in_error = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [63:0] out_data;
    logic        out_startofpacket;
    logic        out_endofpacket;
    logic [2:0]  out_empty;
    logic        out_error;
    logic        status_valid;
    logic [15:0] status_length;
    logic        status_bcast;
    logic        status_mcast;
    logic        status_vlan;
    logic        status_undersize;
    logic        status_oversize;

    eth_10g_mac_rx_frame_decoder #(
        .MIN_FRAME_LEN (64),
        .MAX_FRAME_LEN (1518)
    ) u_dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .in_valid          (in_valid),
        .in_ready          (in_ready),
        .in_data           (in_data),
        .in_startofpacket  (in_startofpacket),
        .in_endofpacket    (in_endofpacket),
        .in_empty          (in_empty),
        .in_error          (in_error),
        .out_valid         (out_valid),
        .out_ready         (out_ready),
        .out_data          (out_data),
        .out_startofpacket (out_startofpacket),
        .out_endofpacket   (out_endofpacket),
        .out_empty         (out_empty),
        .out_error         (out_error),
        .status_valid      (status_valid),
        .status_length     (status_length),
        .status_bcast      (status_bcast),
        .status_mcast      (status_mcast),
        .status_vlan       (status_vlan),
        .status_undersize  (status_undersize),
        .status_oversize   (status_oversize)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [69:0] beat;  // {sop, eop, empty, error, data}
        logic [21:0] st;    // {valid, length, bcast, mcast, vlan, under, over}
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    bit   rand_mode = 1'b0;
    bit   stall     = 1'b0;

    task automatic check_val(input string tag, input logic [95:0] act, input logic [95:0] exp);
        n_checks++;
        if (act !== exp)
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        else
            n_pass++;
    endtask

    function automatic logic [21:0] mkst(input logic [15:0] len, input logic b, input logic m,
                                          input logic v, input logic u, input logic o);
        return {1'b1, len, b, m, v, u, o};
    endfunction

    // Byte image of a test frame: DA, fixed SA, type/TPID at 12-13, counting payload.
    function automatic logic [63:0] frame_beat(input logic [47:0] da, input bit tag,
                                               input int len, input int b);
        logic [63:0] d;
        logic [7:0]  byt;
        d = 64'd0;
        for (int k = 0; k < 8; k++) begin
            int idx;
            idx = b * 8 + k;
            if (idx < 6)        byt = da[47 - 8*idx -: 8];
            else if (idx < 12)  byt = 8'(8'h02 + idx);
            else if (idx == 12) byt = tag ? 8'h81 : 8'h08;
            else if (idx == 13) byt = 8'h00;
            else                byt = 8'(idx);
            if (idx >= len) byt = 8'h00;
            d[63 - 8*k -: 8] = byt;
        end
        return d;
    endfunction

    // out_ready owner: updated 2 time units after each rising edge
    always @(posedge clk) begin
        #2;
        out_ready = stall ? 1'b0 : (rand_mode ? 1'($urandom_range(0, 1)) : 1'b1);
    end

    // Output monitor
    always @(negedge clk) begin
        if (reset_n) begin
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    check_val("unexpected_beat", 96'd1, 96'd0);
                end else begin
                    check_val("beat", {26'd0, out_startofpacket, out_endofpacket, out_empty,
                                       out_error, out_data}, {26'd0, exp_q[0].beat});
                    check_val("status", {74'd0, status_valid, status_length, status_bcast,
                                         status_mcast, status_vlan, status_undersize,
                                         status_oversize}, {74'd0, exp_q[0].st});
                    if (out_ready) void'(exp_q.pop_front());
                end
            end else begin
                check_val("status_idle", {74'd0, status_valid, status_length, status_bcast,
                                          status_mcast, status_vlan, status_undersize,
                                          status_oversize}, 96'd0);
            end
        end
    end

    task automatic send(input logic [63:0] d, input logic s, input logic e, input logic [2:0] emp,
                        input logic err, input logic exp_err, input logic [21:0] exp_st);
        int  waited;
        bit  done;
        exp_t x;
        waited = 0;
        done   = 1'b0;
        in_valid = 1'b1;
        in_data  = d;
        in_startofpacket = s;
        in_endofpacket   = e;
        in_empty = emp;
        in_error = err;
        while (!done) begin
            @(negedge clk);
            if (in_ready) begin
                x.beat = {s, e, emp, exp_err, d};
                x.st   = exp_st;
                exp_q.push_back(x);
                done = 1'b1;
            end else if (waited > 1000) begin
                check_val("send_timeout", 96'd1, 96'd0);
                done = 1'b1;
            end
            waited++;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_frame(input logic [47:0] da, input bit tag, input int len, input logic err,
                              input logic exp_err, input logic [21:0] exp_st);
        int beats;
        int emp;
        beats = (len + 7) / 8;
        emp   = beats * 8 - len;
        for (int b = 0; b < beats; b++) begin
            bit last;
            last = (b == beats - 1);
            send(frame_beat(da, tag, len, b), b == 0, last, last ? 3'(emp) : 3'd0,
                 last ? err : 1'b0, last ? exp_err : 1'b0, last ? exp_st : 22'd0);
        end
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        in_valid = 1'b0;
        while (exp_q.size() != 0 && n < 3000) begin
            @(posedge clk);
            n++;
        end
        #1;
        check_val("drain", 96'(exp_q.size()), 96'd0);
    endtask

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_val("rst_in_ready", 96'(in_ready), 96'd1);
        check_val("rst_out", {25'd0, out_valid, out_startofpacket, out_endofpacket, out_empty,
                              out_error, out_data}, 96'd0);
        check_val("rst_status", {74'd0, status_valid, status_length, status_bcast, status_mcast,
                                 status_vlan, status_undersize, status_oversize}, 96'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        idle(2);

        // 64-byte broadcast
        send_frame(48'hFFFF_FFFF_FFFF, 1'b0, 64, 1'b0, 1'b0, mkst(16'd64, 1, 0, 0, 0, 0));
        // 60-byte multicast, undersize
        send_frame(48'h0100_5E00_0001, 1'b0, 60, 1'b0, 1'b1, mkst(16'd60, 0, 1, 0, 1, 0));
        // 1519-byte untagged unicast, oversize
        send_frame(48'h0011_2233_4455, 1'b0, 1519, 1'b0, 1'b1, mkst(16'd1519, 0, 0, 0, 0, 1));
        // 1522-byte tagged unicast, legal
        send_frame(48'h0011_2233_4455, 1'b1, 1522, 1'b0, 1'b0, mkst(16'd1522, 0, 0, 1, 0, 0));
        wait_drain();

        // Three back-to-back frames with random backpressure
        rand_mode = 1'b1;
        send_frame(48'hFFFF_FFFF_FFFF, 1'b0, 64, 1'b0, 1'b0, mkst(16'd64, 1, 0, 0, 0, 0));
        send_frame(48'h0A0B_0C0D_0E0F, 1'b0, 72, 1'b1, 1'b1, mkst(16'd72, 0, 0, 0, 0, 0));
        send_frame(48'h3333_0000_0001, 1'b0, 100, 1'b0, 1'b0, mkst(16'd100, 0, 1, 0, 0, 0));
        wait_drain();
        rand_mode = 1'b0;
        idle(2);

        // Reset in the middle of a frame, then a fresh 64-byte frame
        send(frame_beat(48'h0011_2233_4455, 1'b0, 64, 0), 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 22'd0);
        send(frame_beat(48'h0011_2233_4455, 1'b0, 64, 1), 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 22'd0);
        idle(3);
        in_valid = 1'b1;
        in_data  = frame_beat(48'h0011_2233_4455, 1'b0, 64, 2);
        in_startofpacket = 1'b0;
        in_endofpacket   = 1'b0;
        reset_n = 1'b0;
        @(negedge clk);
        check_val("midrst_out", {25'd0, out_valid, out_startofpacket, out_endofpacket, out_empty,
                                 out_error, out_data}, 96'd0);
        check_val("midrst_status", {79'd0, status_valid, status_length}, 96'd0);
        @(posedge clk);
        #1;
        reset_n  = 1'b1;
        in_valid = 1'b0;
        idle(1);
        send_frame(48'h0011_2233_4455, 1'b0, 64, 1'b0, 1'b0, mkst(16'd64, 0, 0, 0, 0, 0));
        wait_drain();

        // Single-beat frame (TPID pattern present but must not count as VLAN), held in a stall
        stall = 1'b1;
        idle(1);
        send(64'h0123_4567_8100_CDEF, 1'b1, 1'b1, 3'd2, 1'b0, 1'b1, mkst(16'd6, 0, 1, 0, 1, 0));
        in_valid = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check_val("stall_in_ready", 96'(in_ready), 96'd0);
        end
        @(posedge clk);
        #1;
        stall = 1'b0;
        // Stray non-SOP EOP beat in IDLE: untouched, no status
        send(64'hDEAD_BEEF_0000_1111, 1'b0, 1'b1, 3'd5, 1'b0, 1'b0, 22'd0);
        wait_drain();

        // Length saturation: 65544 bytes reports 0xFFFF and oversize
        send_frame(48'h0011_2233_4455, 1'b0, 65544, 1'b0, 1'b1, mkst(16'hFFFF, 0, 0, 0, 0, 1));
        wait_drain();
        idle(3);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
